// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types and constants for the writeback trace buffer.
//   trace_rec_t    : one captured register-file write {pc, wnum, wen, wdata}
//   trace_state_e  : capture FSM states (RUN, ENDING, DONE)
//   END_PC_DEFAULT : PC whose retirement terminates capture
//   mask_bytes()   : zeroes the data bytes whose write enable is low
// -----------------------------------------------------------------------------
package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENDING = 2'd1,
    DONE   = 2'd2
  } trace_state_e;

  localparam logic [31:0] END_PC_DEFAULT = 32'h8000_0010;

  function automatic logic [31:0] mask_bytes(input logic [31:0] data,
                                             input logic [3:0]  wen);
    return data & {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction

endpackage

// File: rtl/wb_trace_buf_if.sv
// -----------------------------------------------------------------------------
// wb_trace_buf_if
// Bundles the CPU writeback debug port and the record drain stream.
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata : writeback observed from the core
//   out_valid/out_ready                 : drain handshake
//   out_pc/out_wnum/out_wen/out_wdata   : head record
// Modports: master = core + trace consumer side, slave = the trace buffer.
// -----------------------------------------------------------------------------
interface wb_trace_buf_if;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_wnum;
  logic [3:0]  out_wen;
  logic [31:0] out_wdata;

  modport master (
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output out_ready,
    input  out_valid, out_pc, out_wnum, out_wen, out_wdata
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  out_ready,
    output out_valid, out_pc, out_wnum, out_wen, out_wdata
  );
endinterface

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO of trace_rec_t with a registered head stage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, push_data_i : write one record (caller guarantees !full_o || pop_i)
//   pop_i         : consume head (caller guarantees valid_o)
//   head_o, valid_o : head record, zero while not valid
//   full_o, empty_o, count_o : occupancy, count_o in 0..DEPTH
// Storage is an array read into a head register, so a record written at one
// edge becomes visible on head_o after the following edge.
// -----------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  trace_rec_t    push_data_i,
  input  logic          pop_i,
  output trace_rec_t    head_o,
  output logic          valid_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  trace_rec_t    mem [DEPTH];
  trace_rec_t    head_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] mem_cnt;
  logic          fetch;

  // count_q includes the record held in the head register.
  assign mem_cnt = count_q - CW'(valid_q);
  // Refill the head whenever it is empty or being consumed this cycle.
  assign fetch   = (mem_cnt != '0) && (!valid_q || pop_i);
  assign count_d = count_q + CW'(push_i) - CW'(pop_i);
  assign valid_d = fetch ? 1'b1 : (pop_i ? 1'b0 : valid_q);

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (fetch) head_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fetch)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = valid_q ? head_q : '0;
  assign valid_o = valid_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/wb_trace_buf.sv
// -----------------------------------------------------------------------------
// wb_trace_buf
// Captures register-file writes from the CPU writeback debug port into a
// FIFO and drains them over a valid/ready stream. Capture stops once END_PC
// is seen; trace_end rises after the remaining records have drained. A full
// FIFO never stalls the core: records are dropped and counted instead.
//   clk_50M, resetn : clock, asynchronous active-low reset
//   wb (slave)      : debug_wb_* inputs, out_* record stream
//   trace_end       : capture finished and FIFO drained
//   overflow        : sticky, at least one record dropped
//   drop_cnt        : dropped records, saturating at 16'hFFFF
//   count           : FIFO occupancy, 0..DEPTH
// Build option: TRACE_FILTER_X0_EN ignores writes to x0 (neither captured
// nor counted as drops).
// -----------------------------------------------------------------------------
module wb_trace_buf
  import trace_pkg::*;
#(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = END_PC_DEFAULT
) (
  input  logic                   clk_50M,
  input  logic                   resetn,
  wb_trace_buf_if.slave          wb,
  output logic                   trace_end,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] count
);

  trace_state_e state_q, state_d;
  logic         overflow_q;
  logic [15:0]  drop_cnt_q;
  logic         x0_filtered;
  logic         wb_event, push, pop, drop;
  logic         fifo_full, fifo_empty, head_valid;
  trace_rec_t   rec, head;

`ifdef TRACE_FILTER_X0_EN
  assign x0_filtered = (wb.debug_wb_rf_wnum == 5'd0);
`else
  assign x0_filtered = 1'b0;
`endif

  assign wb_event = (state_q == RUN) && (|wb.debug_wb_rf_wen) && !x0_filtered;
  assign pop      = head_valid && wb.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = wb_event && (!fifo_full || pop);
  assign drop     = wb_event && fifo_full && !pop;

  assign rec.pc    = wb.debug_wb_pc;
  assign rec.wnum  = wb.debug_wb_rf_wnum;
  assign rec.wen   = wb.debug_wb_rf_wen;
  assign rec.wdata = mask_bytes(wb.debug_wb_rf_wdata, wb.debug_wb_rf_wen);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_50M),
    .rst_ni      (resetn),
    .push_i      (push),
    .push_data_i (rec),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (head_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wb.debug_wb_pc == END_PC) state_d = ENDING;
      ENDING:  if (fifo_empty) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_50M or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign wb.out_valid = head_valid;
  assign wb.out_pc    = head.pc;
  assign wb.out_wnum  = head.wnum;
  assign wb.out_wen   = head.wen;
  assign wb.out_wdata = head.wdata;
  assign trace_end    = (state_q == DONE);
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buf.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buf
// Randomised and directed stimulus against a queue-based reference model;
// a monitor compares every drained record and the status outputs each cycle.
// -----------------------------------------------------------------------------
module tb_wb_trace_buf;
  import trace_pkg::*;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] END_PC = 32'h8000_0010;
`ifdef TRACE_FILTER_X0_EN
  localparam bit FILTER_X0 = 1'b1;
`else
  localparam bit FILTER_X0 = 1'b0;
`endif

  logic clk_50M = 1'b0;
  logic resetn;
  always #5 clk_50M = ~clk_50M;

  wb_trace_buf_if bus ();
  logic        trace_end, overflow;
  logic [15:0] drop_cnt;
  logic [4:0]  count;

  wb_trace_buf #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk_50M   (clk_50M),
    .resetn    (resetn),
    .wb        (bus.slave),
    .trace_end (trace_end),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .count     (count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mask(input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // ---------------- reference model ----------------
  // exp_q : records the consumer must receive, in order (scoreboard)
  // occ   : edge index at which each held record was captured; a record is
  //         visible at the head once at least one further edge has passed
  trace_rec_t exp_q[$];
  int         occ[$];
  int         edge_no   = 0;
  bit         exp_valid = 1'b0;
  int         m_state   = 0;   // 0 capturing, 1 ending, 2 done
  int         m_drops   = 0;
  bit         m_ovf     = 1'b0;

  initial begin
    bit         m_pop, m_full, m_event;
    int         size_before;
    trace_rec_t r;
    forever begin
      @(posedge clk_50M or negedge resetn);
      if (!resetn) begin
        exp_q.delete();
        occ.delete();
        exp_valid = 1'b0;
        m_state   = 0;
        m_drops   = 0;
        m_ovf     = 1'b0;
      end else begin
        edge_no++;
        m_pop       = exp_valid && bus.out_ready;
        size_before = occ.size();
        m_full      = (size_before == DEPTH);
        m_event     = (m_state == 0) && (bus.debug_wb_rf_wen != 4'h0) &&
                      !(FILTER_X0 && bus.debug_wb_rf_wnum == 5'd0);
        if (m_pop && occ.size() > 0) void'(occ.pop_front());
        if (m_event) begin
          if (!m_full || m_pop) begin
            occ.push_back(edge_no);
            r.pc    = bus.debug_wb_pc;
            r.wnum  = bus.debug_wb_rf_wnum;
            r.wen   = bus.debug_wb_rf_wen;
            r.wdata = ref_mask(bus.debug_wb_rf_wdata, bus.debug_wb_rf_wen);
            exp_q.push_back(r);
          end else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
          end
        end
        if (m_state == 0 && bus.debug_wb_pc == END_PC) m_state = 1;
        else if (m_state == 1 && size_before == 0)    m_state = 2;
        exp_valid = (occ.size() > 0) && (occ[0] < edge_no);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    trace_rec_t e;
    forever begin
      @(negedge clk_50M);
      if (resetn) begin
        chk("count",     64'(count),         64'(occ.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("overflow",  64'(overflow),      64'(m_ovf));
        chk("drop_cnt",  64'(drop_cnt),      64'(m_drops));
        chk("trace_end", 64'(trace_end),     64'(m_state == 2));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_record", 64'(bus.out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rec_pc",    64'(bus.out_pc),    64'(e.pc));
            chk("rec_wnum",  64'(bus.out_wnum),  64'(e.wnum));
            chk("rec_wen",   64'(bus.out_wen),   64'(e.wen));
            chk("rec_wdata", 64'(bus.out_wdata), 64'(e.wdata));
            $display("REC pc=%h wnum=%0d wen=%h wdata=%h", bus.out_pc,
                     bus.out_wnum, bus.out_wen, bus.out_wdata);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] pc, input logic [3:0] wen,
                       input logic [4:0] wnum, input logic [31:0] wdata,
                       input logic rdy);
    @(posedge clk_50M);
    #1;
    bus.debug_wb_pc       = pc;
    bus.debug_wb_rf_wen   = wen;
    bus.debug_wb_rf_wnum  = wnum;
    bus.debug_wb_rf_wdata = wdata;
    bus.out_ready         = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(32'h8000_0000, 4'h0, 5'd0, 32'h0, rdy);
  endtask

  task automatic random_phase(input int n);
    int ready_pct;
    ready_pct = 70;
    for (int i = 0; i < n; i++) begin
      if (i % 40 == 0) ready_pct = $urandom_range(0, 100);
      drive(32'h8000_0100 + 32'($urandom_range(0, 1000)) * 4,
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
            5'($urandom), $urandom,
            ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    resetn                = 1'b0;
    bus.debug_wb_pc       = '0;
    bus.debug_wb_rf_wen   = '0;
    bus.debug_wb_rf_wnum  = '0;
    bus.debug_wb_rf_wdata = '0;
    bus.out_ready         = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
    chk("rst_out_wdata", 64'(bus.out_wdata), 64'd0);
    chk("rst_count",     64'(count),         64'd0);
    chk("rst_overflow",  64'(overflow),      64'd0);
    chk("rst_drop_cnt",  64'(drop_cnt),      64'd0);
    chk("rst_trace_end", 64'(trace_end),     64'd0);
    @(negedge clk_50M);
    resetn = 1'b1;

    // single capture with partial byte enables
    drive(32'h8000_0000, 4'b0011, 5'd2, 32'hDEAD_BEEF, 1'b1);
    idle(4, 1'b1);

    // overflow: 20 events into a stalled 16-deep FIFO
    for (int i = 0; i < 20; i++)
      drive(32'h8000_1000 + 32'(i) * 4, 4'hF, 5'(i + 1), $urandom, 1'b0);
    idle(1, 1'b0);
    @(negedge clk_50M);
    chk("ovf_count", 64'(count),    64'd16);
    chk("ovf_drop",  64'(drop_cnt), 64'd4);
    chk("ovf_flag",  64'(overflow), 64'd1);
    // full FIFO with push and pop in the same cycle
    drive(32'h8000_2000, 4'hF, 5'd9, 32'h1111_2222, 1'b1);
    idle(1, 1'b0);
    @(negedge clk_50M);
    chk("fullpp_count", 64'(count),    64'd16);
    chk("fullpp_drop",  64'(drop_cnt), 64'd4);
    idle(24, 1'b1);

    // x0 write
    drive(32'h8000_0200, 4'hF, 5'd0, 32'h1234_5678, 1'b0);
    idle(1, 1'b0);
    @(negedge clk_50M);
    chk("x0_count", 64'(count), FILTER_X0 ? 64'd0 : 64'd1);
    idle(4, 1'b1);

    random_phase(400);
    idle(24, 1'b1);

    // reset while records are queued
    for (int i = 0; i < 5; i++)
      drive(32'h8000_3000 + 32'(i) * 4, 4'hF, 5'd3, $urandom, 1'b0);
    idle(1, 1'b0);
    @(posedge clk_50M);
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_count",     64'(count),         64'd0);
    chk("mid_rst_drop_cnt",  64'(drop_cnt),      64'd0);
    @(negedge clk_50M);
    resetn = 1'b1;
    random_phase(120);
    idle(24, 1'b1);

    // end of trace: 3 records, END_PC with an event, later events ignored
    for (int i = 0; i < 3; i++)
      drive(32'h8000_4000 + 32'(i) * 4, 4'hF, 5'd4, $urandom, 1'b0);
    drive(END_PC, 4'hF, 5'd7, 32'hCAFE_F00D, 1'b0);
    drive(32'h8000_5000, 4'hF, 5'd8, 32'h5555_5555, 1'b0);
    drive(END_PC, 4'hF, 5'd9, 32'h6666_6666, 1'b0);
    idle(1, 1'b0);
    @(negedge clk_50M);
    chk("end_count", 64'(count), 64'd4);
    chk("end_trace_end_early", 64'(trace_end), 64'd0);
    for (int i = 0; i < 12; i++)
      drive(32'h8000_6000 + 32'(i) * 4, 4'hF, 5'd10, $urandom, 1'b1);
    @(negedge clk_50M);
    chk("end_trace_end", 64'(trace_end), 64'd1);
    chk("end_count_final", 64'(count), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_buf.md
# wb_trace_buf

Synthesizable capture buffer for the CPU's writeback debug port. It sits in `thinpad_top` between the core's `debug_wb_*` outputs and the trace consumer, such as a UART dumper or an on-board comparator. Each register-file write is queued as a byte-lane-masked record and drained over a valid/ready interface. Capture stops once the end PC retires, and overflow is counted rather than stalling the core.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2
- `END_PC`, 32'h8000_0010: PC that terminates capture
- `clk_50M`  in  1  CPU clock; all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `debug_wb_pc`  in  32  PC of the writeback instruction
- `debug_wb_rf_wen`  in  4  per-byte write enable
- `debug_wb_rf_wnum`  in  5  destination register
- `debug_wb_rf_wdata`  in  32  write data
- `out_valid`  out  1  head record available
- `out_ready`  in  1  consumer accepts head record
- `out_pc`  out  32  record PC
- `out_wnum`  out  5  record register number
- `out_wen`  out  4  record byte enables
- `out_wdata`  out  32  record data, bytes with `wen[i]==0` forced to 0
- `trace_end`  out  1  capture finished and FIFO drained
- `overflow`  out  1  sticky; at least one record dropped
- `drop_cnt`  out  16  dropped records, saturating at 16'hFFFF
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **Event.** An event occurs when `|debug_wb_rf_wen` is high and the state is RUN.
- **Record.** Each event forms the record {pc, wnum, wen, masked wdata}. Byte lane i of wdata is ANDed with `{8{wen[i]}}`.
- **States:**
  - RUN: capture events. When `debug_wb_pc == END_PC`, go to ENDING. An event in that same cycle is still captured.
  - ENDING: no capture. When the FIFO is empty, go to DONE.
  - DONE: no capture; `trace_end` = 1. Leave only by reset.
- **Push.** A push happens on an event in RUN.
- **Pop.** A pop happens when `out_valid && out_ready`.
- **Full FIFO with pop in the same cycle.** Push and pop both succeed; `count` is unchanged.
- **Full FIFO without a pop.** The record is dropped. `overflow` is set and `drop_cnt` increments (saturating). The core is never back-pressured.
- **Empty FIFO with a push in the same cycle.** No pop occurs; the record becomes visible the next cycle.
- **Pointers.** Pointers wrap modulo DEPTH; `count` is 0..DEPTH.
- **Out-of-order states.** ENDING and DONE ignore `debug_wb_*` entirely, including a repeated END_PC.

## Timing
- **Reset values.** All outputs are 0 and the state is RUN. FIFO pointers, `count`, `drop_cnt`, `overflow` and `trace_end` are all cleared.
- **Reset mid-operation.** Asserting `resetn` low discards FIFO contents immediately, without waiting for a clock edge.
- **Capture latency.** An event sampled at edge N appears on `out_*` with `out_valid` = 1 after edge N+1 if the FIFO was empty.
- **Output stability.** `out_*` hold stable while `out_valid && !out_ready`.
- **Throughput.** One record per cycle in and one out, sustained.
- **`trace_end` timing.** `trace_end` rises the cycle after the pop that empties the FIFO while in ENDING. If END_PC is seen with the FIFO empty and no event that cycle, `trace_end` rises one cycle after entering ENDING.

## Configuration
- `TRACE_FILTER_X0_EN` defined: events with `debug_wb_rf_wnum == 0` are not captured and do not count as drops. This matches the golden-trace comparison rule.
- `TRACE_FILTER_X0_EN` undefined: writes to x0 are captured like any other.

## Structure
- **Package `trace_pkg`:**
  - `trace_rec_t` packed struct {pc[31:0], wnum[4:0], wen[3:0], wdata[31:0]}
  - `trace_state_e` enum {RUN, ENDING, DONE}
  - default END_PC constant
- **Sub-module `trace_fifo`:**
  - synchronous FIFO of `trace_rec_t`, parameter DEPTH
  - push/pop/full/empty/count ports
  - `wb_trace_buf` holds the FSM, masking, filtering and drop accounting

## Test plan
- **Single capture.** Reset, then one event: pc=8000_0000, wnum=2, wen=4'b0011, wdata=DEADBEEF, with `out_ready`=1.
  - Expect `out_valid` one cycle later with wdata=0000BEEF, wnum=2; then `count` returns to 0.
- **Overflow.** DEPTH=16, `out_ready`=0, 20 consecutive events.
  - Expect `count`=16, `overflow`=1, `drop_cnt`=4.
  - Then raise `out_ready`: 16 records drain in order (the first 16 PCs).
- **Full FIFO with simultaneous push and pop.** Push and pop in the same cycle.
  - Expect `count` to stay 16 and `drop_cnt` unchanged.
- **End of trace.** 3 records queued, `out_ready`=0, then `debug_wb_pc`=8000_0010 with an event.
  - Expect 4 records queued and no later event captured.
  - `trace_end` rises the cycle after the 4th pop.
- **x0 filter.** Event with wnum=0, wen=4'hF.
  - With `TRACE_FILTER_X0_EN` defined: `count` stays 0.
  - Without it: one record with wnum=0.
- **Reset mid-drain.** Assert `resetn`=0 with 5 records queued.
  - Expect immediate `out_valid`=0, `count`=0, `drop_cnt`=0.
  - After release, the state is RUN and capture resumes.
